pc_fetch_unit: RTL

Program-counter register and instruction-fetch sequencer for the 16-bit datapath. It drives `pc_plus2` into the sequential input of the next-PC `mux2to1` and consumes that mux's output as `next_pc`. It issues one instruction-memory request per PC value and holds the PC until the control unit accepts the fetched instruction.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_fetch_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit datapath.
//   pc_state_t           - fetch sequencer states (2 bits)
//   PC_INCR              - sequential PC increment (bytes per instruction)
//   RESET_VECTOR_DEFAULT - default PC value after reset
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  localparam int unsigned PC_INCR              = 2;
  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'h0000;

endpackage

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Issues one instruction-memory request per PC value and holds the PC until
// the control unit accepts the fetched instruction with `load`.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   next_pc      - next-PC value from the external mux2to1
//   load         - accept current instruction, advance PC to next_pc
//   halt_req     - stop fetching (level, sampled in READY)
//   imem_ack     - instruction memory has data for imem_addr
//   imem_req     - fetch request (FETCH state)
//   imem_addr    - fetch address, always equals pc
//   pc           - current PC register
//   pc_plus2     - pc + 2 (wrapping), feeds mux2to1 input1
//   instr_valid  - fetched instruction available (READY state)
//   halted       - unit is in HALT
//   misaligned   - sticky misaligned-load flag
//
// Build option: define PC_ALIGN_CHECK_EN to halt (and set `misaligned`) on a
// load of an odd next_pc. Without it, bit 0 of next_pc is cleared and
// `misaligned` is tied low.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     SIZE         = 16,
  parameter logic [SIZE-1:0] RESET_VECTOR = SIZE'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] next_pc,
  input  logic            load,
  input  logic            halt_req,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic [SIZE-1:0] imem_addr,
  output logic [SIZE-1:0] pc,
  output logic [SIZE-1:0] pc_plus2,
  output logic            instr_valid,
  output logic            halted,
  output logic            misaligned
);

  pc_state_t       state_reg, state_next;
  logic [SIZE-1:0] pc_reg, pc_next;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_reg, misaligned_next;
`endif

  // State and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_VECTOR;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_reg <= 1'b0;
    end else begin
      misaligned_reg <= misaligned_next;
    end
  end
  assign misaligned = misaligned_reg;
`else
  assign misaligned = 1'b0;
`endif

  // Next-state logic; outputs are decoded from the registered state only
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misaligned_next = misaligned_reg;
`endif
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = READY;
        end
      end
      READY: begin
        instr_valid = 1'b1;
        if (halt_req) begin
          state_next = HALT;
        end else if (load) begin
`ifdef PC_ALIGN_CHECK_EN
          if (next_pc[0]) begin
            misaligned_next = 1'b1;
            state_next      = HALT;
          end else begin
            pc_next    = next_pc;
            state_next = FETCH;
          end
`else
          // Force halfword alignment by masking bit 0.
          pc_next    = next_pc & ~{{(SIZE-1){1'b0}}, 1'b1};
          state_next = FETCH;
`endif
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pc        = pc_reg;
  assign imem_addr = pc_reg;
  assign pc_plus2  = pc_reg + SIZE'(PC_INCR);

endmodule
